ncl_sync_rx: RTL and testbench



---
 rtl/ncl_sync_rx.sv | 166 ++++++++++++++++
 tb/tb_ncl_sync_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ncl_sync_rx.sv
// ncl_sync_rx: clocked receiver at the tail of the dual-rail NCL adder pipeline.
// Synchronizes every rail, detects complete DATA / all-NULL wavefronts, drives
// the NCL acknowledge (ko) from a flop and hands each captured word to the
// synchronous side through a one-entry valid/ready buffer.
module ncl_sync_rx #(
  parameter int DW          = 9,   // 8 sum bits + carry-out
  parameter int SYNC_STAGES = 2,   // synchronizer depth, 2..4
  parameter int CNT_W       = 16   // completed-word counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    d_rail1,
  input  logic [DW-1:0]    d_rail0,
  output logic             ko,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic [CNT_W-1:0] word_cnt
);

  // FLUSH and WAIT_NULL both wait for NULL with ko low; FLUSH additionally
  // waits for the synchronizers to hold real post-reset samples.
  typedef enum logic [1:0] {
    ST_FLUSH     = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_WAIT_NULL = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer chains, one per rail. Index 0 is the first stage, index
  // SYNC_STAGES-1 is the stage all detection logic looks at.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][DW-1:0] r_sync1;
  logic [SYNC_STAGES-1:0][DW-1:0] r_sync0;

  // Fill tracker: a 1 shifts in behind the reset so we know when the last
  // synchronizer stage holds a sample taken after reset. Without it the
  // cleared flops would look like a NULL wavefront and FLUSH could accept a
  // stale DATA word still sitting on the inputs.
  logic [SYNC_STAGES-1:0] r_fill;

  // Shift every rail through the synchronizer chain and track fill status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync0 <= '0;
      r_fill  <= '0;
    end else begin
      r_sync1 <= {r_sync1[SYNC_STAGES-2:0], d_rail1};
      r_sync0 <= {r_sync0[SYNC_STAGES-2:0], d_rail0};
      r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // Completion detection on the final synchronizer stage
  // ---------------------------------------------------------------------------
  logic [DW-1:0] w_s1;
  logic [DW-1:0] w_s0;
  logic          w_complete;
  logic          w_is_null;
  logic          w_illegal;
  logic          w_filled;

  assign w_s1       = r_sync1[SYNC_STAGES-1];
  assign w_s0       = r_sync0[SYNC_STAGES-1];
  // Every pair has exactly one rail high (an illegal pair fails this too).
  assign w_complete = &(w_s1 ^ w_s0);
  assign w_is_null  = ~|(w_s1 | w_s0);
  assign w_illegal  = |(w_s1 & w_s0);
  assign w_filled   = r_fill[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Handshake FSM and output buffer registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ko;
  logic              w_ko_nxt;
  logic              w_cap;
  logic              w_pop;
  logic [DW-1:0]     r_out_data;
  logic              r_out_valid;
  logic              r_err;
  logic [CNT_W-1:0]  r_word_cnt;

  // A buffered word leaves whenever the consumer takes it.
  assign w_pop = r_out_valid & out_ready;

  // State register plus the ko flop, so ko never glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FLUSH;
      r_ko    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ko    <= w_ko_nxt;
    end
  end

  // Next-state / capture decision; an illegal sample never moves the FSM
  always_comb begin
    w_state_nxt = r_state;
    w_ko_nxt    = r_ko;
    w_cap       = 1'b0;
    unique case (r_state)
      ST_FLUSH: begin
        if (w_filled && w_is_null && !w_illegal) begin
          w_state_nxt = ST_WAIT_DATA;
          w_ko_nxt    = 1'b1;
        end
      end
      ST_WAIT_DATA: begin
        // A complete word waits here (ko held high) while the buffer is
        // full and not being drained: that stalls upstream in DATA.
        if (w_complete && !w_illegal && (!r_out_valid || out_ready)) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_WAIT_NULL;
          w_ko_nxt    = 1'b0;
        end
      end
      ST_WAIT_NULL: begin
        if (w_is_null && !w_illegal) begin
          w_state_nxt = ST_WAIT_DATA;
          w_ko_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_FLUSH;
        w_ko_nxt    = 1'b0;
      end
    endcase
  end

  // One-entry buffer: capture wins over pop, so capture+pop keeps valid high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_word_cnt  <= '0;
    end else if (w_cap) begin
      r_out_data  <= w_s1;
      r_out_valid <= 1'b1;
      r_word_cnt  <= r_word_cnt + 1'b1;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky protocol-violation flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_illegal) begin
      r_err <= 1'b1;
    end
  end

  assign ko        = r_ko;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign err       = r_err;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_ncl_sync_rx.sv
// Directed bench for ncl_sync_rx with a cycle-level protocol model.
module tb_ncl_sync_rx;
  localparam int DW    = 9;
  localparam int SS    = 2;
  localparam int CNT_W = 4;
  localparam logic [DW-1:0] ALL1 = '1;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    d_rail1, d_rail0;
  logic             ko;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             err;
  logic [CNT_W-1:0] word_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  ncl_sync_rx #(.DW(DW), .SYNC_STAGES(SS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .d_rail1(d_rail1), .d_rail0(d_rail0), .ko(ko),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h want 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Model: the receiver sees the rails SS edges late; ko means "expecting
  // DATA". A complete legal word is taken only while expecting DATA and the
  // buffer is free or draining; an all-NULL sample re-arms ko. Samples taken
  // before the reset has been flushed through are ignored.
  logic [DW-1:0] h1 [SS];
  logic [DW-1:0] h0 [SS];
  bit            hv [SS];
  bit            m_ko, m_v, m_err;
  logic [DW-1:0] m_data;
  int            m_cnt;

  always @(posedge clk) begin : model
    logic [DW-1:0] v1, v0;
    bit vv, cap;
    if (rst) begin
      for (int i = 0; i < SS; i++) begin h1[i] = '0; h0[i] = '0; hv[i] = 0; end
      m_ko = 0; m_v = 0; m_err = 0; m_data = '0; m_cnt = 0;
    end else begin
      v1 = h1[SS-1]; v0 = h0[SS-1]; vv = hv[SS-1];
      cap = 0;
      if ((v1 & v0) != '0) m_err = 1;
      else if (vv) begin
        if (m_ko && ((v1 ^ v0) == ALL1) && (!m_v || out_ready)) begin
          cap = 1; m_data = v1; m_v = 1; m_ko = 0;
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end else if (!m_ko && (v1 | v0) == '0) m_ko = 1;
      end
      if (!cap && m_v && out_ready) m_v = 0;
      for (int i = SS-1; i > 0; i--) begin h1[i] = h1[i-1]; h0[i] = h0[i-1]; hv[i] = hv[i-1]; end
      h1[0] = d_rail1; h0[0] = d_rail0; hv[0] = 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ko", {31'd0, ko}, {31'd0, m_ko});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_v});
      chk("out_data", {23'd0, out_data}, {23'd0, m_data});
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("word_cnt", {28'd0, word_cnt}, m_cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put(input logic [DW-1:0] v);
    d_rail1 = v; d_rail0 = ~v;
  endtask

  task automatic put_null();
    d_rail1 = '0; d_rail0 = '0;
  endtask

  initial begin
    logic [DW-1:0] pv;
    // Reset with a stale DATA wavefront held on the rails
    rst = 1; out_ready = 0; put(9'h0A5);
    tick(1);
    rst = 0; chk_en = 1;
    chk("rst_ko", {31'd0, ko}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_cnt", {28'd0, word_cnt}, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("flush_ko", {31'd0, ko}, 0);
      chk("flush_valid", {31'd0, out_valid}, 0);
    end
    put_null(); tick(2);
    chk("flush_ko_early", {31'd0, ko}, 0);
    tick(1);
    chk("flush_ko_rise", {31'd0, ko}, 1);
    chk("flush_nocap", {28'd0, word_cnt}, 0);

    // Single word, 3 edges of latency
    out_ready = 1; d_rail1 = 9'h1C3; d_rail0 = 9'h03C;
    tick(2);
    chk("single_notyet", {31'd0, out_valid}, 0);
    tick(1);
    chk("single_valid", {31'd0, out_valid}, 1);
    chk("single_data", {23'd0, out_data}, 32'h1C3);
    chk("single_ko", {31'd0, ko}, 0);
    chk("model_single", {23'd0, m_data}, 32'h1C3);
    put_null(); tick(2);
    chk("single_ko_low", {31'd0, ko}, 0);
    tick(1);
    chk("single_ko_rise", {31'd0, ko}, 1);
    chk("single_cnt", {28'd0, word_cnt}, 1);

    // Backpressure then simultaneous capture+pop
    out_ready = 0; put(9'h001); tick(3);
    chk("bp_first", {23'd0, out_data}, 32'h001);
    put_null(); tick(3);
    put(9'h0FF); tick(5);
    chk("bp_ko_held", {31'd0, ko}, 1);
    chk("bp_data_held", {23'd0, out_data}, 32'h001);
    chk("bp_valid", {31'd0, out_valid}, 1);
    out_ready = 1; tick(1);
    chk("bp_swap_valid", {31'd0, out_valid}, 1);
    chk("bp_swap_data", {23'd0, out_data}, 32'h0FF);
    chk("bp_swap_ko", {31'd0, ko}, 0);
    chk("bp_cnt", {28'd0, word_cnt}, 3);
    put_null(); tick(3);

    // Partial wavefront, one bit per cycle
    pv = 9'h155;
    for (int i = 0; i < DW; i++) begin
      if (pv[i]) d_rail1[i] = 1'b1; else d_rail0[i] = 1'b1;
      tick(1);
      chk("part_ko", {31'd0, ko}, 1);
    end
    tick(1);
    chk("part_nocap", {31'd0, out_valid}, 0);
    tick(1);
    chk("part_cap", {23'd0, out_data}, 32'h155);
    chk("part_valid", {31'd0, out_valid}, 1);
    put_null(); tick(3);

    // Illegal pair on bit 3, then corrected
    d_rail1 = 9'h0A8; d_rail0 = 9'h15F; tick(3);
    chk("ill_err", {31'd0, err}, 1);
    chk("model_err", {31'd0, m_err}, 1);
    tick(3);
    chk("ill_nocap", {31'd0, out_valid}, 0);
    chk("ill_ko", {31'd0, ko}, 1);
    chk("ill_cnt", {28'd0, word_cnt}, 4);
    d_rail1 = 9'h0A0; tick(3);
    chk("ill_fix_data", {23'd0, out_data}, 32'h0A0);
    chk("ill_fix_cnt", {28'd0, word_cnt}, 5);
    chk("ill_sticky", {31'd0, err}, 1);
    put_null(); tick(3);

    // Reset mid-operation with a buffered word and DATA present
    out_ready = 0; put(9'h033); tick(3);
    chk("mid_pre_valid", {31'd0, out_valid}, 1);
    rst = 1; tick(1); rst = 0;
    chk("mid_valid", {31'd0, out_valid}, 0);
    chk("mid_ko", {31'd0, ko}, 0);
    chk("mid_err", {31'd0, err}, 0);
    chk("mid_cnt", {28'd0, word_cnt}, 0);
    tick(4);
    chk("mid_stale_ko", {31'd0, ko}, 0);
    put_null(); tick(3);
    chk("mid_rearm", {31'd0, ko}, 1);

    // Counter wrap: 17 words with a 4-bit counter
    out_ready = 1;
    for (int w = 0; w < 17; w++) begin
      put(w[DW-1:0]); tick(3);
      chk("wrap_data", {23'd0, out_data}, w);
      chk("wrap_valid", {31'd0, out_valid}, 1);
      put_null(); tick(3);
    end
    chk("wrap_cnt", {28'd0, word_cnt}, 1);
    chk("model_wrap", m_cnt, 1);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
